// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state encoding and header field positions for the SPI frame controller
package spi_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
  localparam int HDR_RW_BIT = 5;
  localparam int HDR_ADDR_MSB = 4;
  localparam int AW = 5;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchroniser with registered one-cycle rise/fall pulses
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;
  // shift the pin through the synchroniser and compare against the previous synchronised level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end
  // flops start at the idle pin level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{INIT}};
      prev_q <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: SPI mode-0 slave frame sequencer driving header decoder, register writes and burst reads
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSCLK,
  input  logic          iCS_N,
  input  logic          MOSI,
  output logic          oMISO,
  output logic          oDEC_EN,
  output logic          oDEC_CLR,
  input  logic [5:0]    iHEADER,
  input  logic          iHEADER_EN,
  output logic          oWR_EN,
  output logic [AW-1:0] oWR_ADDR,
  output logic [DW-1:0] oWR_DATA,
  output logic          oRD_EN,
  output logic [AW-1:0] oRD_ADDR,
  input  logic [DW-1:0] iRD_DATA
);
  localparam int CW = $clog2(DW);
  logic sclk_rise, sclk_fall, cs_act, cs_deact, mosi_s;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [DW-1:0] rx_q, rx_d, tx_q, tx_d, hold_q, hold_d, wr_data_q, wr_data_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic rw_q, rw_d, first_q, first_d, load_pend_q, load_pend_d, rd_pend_q, rd_pend_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk(iCLK), .rst(iRST), .in(iSCLK), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk(iCLK), .rst(iRST), .in(iCS_N), .rise(cs_deact), .fall(cs_act)
  );
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  // frame sequencing: cs_deact overrides everything, otherwise step the header/data phases
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rw_d = rw_q;
    bitcnt_d = bitcnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    hold_d = rd_pend_q ? iRD_DATA : hold_q;
    first_d = first_q;
    load_pend_d = load_pend_q;
    rd_pend_d = rd_en_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d = 1'b0;
    rd_addr_d = rd_addr_q;
    mosi_d = {mosi_q[SYNC_STAGES-2:0], MOSI};
    oDEC_EN = 1'b0;
    oDEC_CLR = 1'b0;
    if (rd_pend_q && first_q) begin
      tx_d = iRD_DATA;
      first_d = 1'b0;
    end
    if (cs_deact) begin
      state_d = IDLE;
      oDEC_CLR = 1'b1;
      bitcnt_d = '0;
      first_d = 1'b0;
      load_pend_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = cs_act ? HEADER : IDLE;
      oDEC_CLR = cs_act;
    end else if (state_q == HEADER) begin
      oDEC_EN = sclk_rise;
      if (iHEADER_EN) begin
        state_d = DATA;
        addr_d = iHEADER[HDR_ADDR_MSB:0];
        rw_d = iHEADER[HDR_RW_BIT];
        bitcnt_d = '0;
        rd_en_d = iHEADER[HDR_RW_BIT];
        rd_addr_d = iHEADER[HDR_ADDR_MSB:0];
        first_d = iHEADER[HDR_RW_BIT];
        load_pend_d = 1'b0;
      end
    end else begin
      if (sclk_fall && bitcnt_q == '0 && load_pend_q) begin
        tx_d = hold_q;
        load_pend_d = 1'b0;
      end else if (sclk_fall && bitcnt_q != '0) begin
        tx_d = tx_q << 1;
      end
      if (sclk_rise) begin
        rx_d = {rx_q[DW-2:0], mosi_s};
        bitcnt_d = bitcnt_q + CW'(1);
        if (bitcnt_q == CW'(DW-1)) begin
          bitcnt_d = '0;
          addr_d = addr_q + AW'(1);
          load_pend_d = rw_q;
          rd_en_d = rw_q;
          rd_addr_d = rw_q ? addr_q + AW'(1) : rd_addr_q;
          wr_en_d = ~rw_q;
          wr_addr_d = rw_q ? wr_addr_q : addr_q;
          wr_data_d = rw_q ? wr_data_q : {rx_q[DW-2:0], mosi_s};
        end
      end
    end
  end
  // state and datapath registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      addr_q <= '0;
      rw_q <= 1'b0;
      bitcnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      hold_q <= '0;
      first_q <= 1'b0;
      load_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      mosi_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rw_q <= rw_d;
      bitcnt_q <= bitcnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      hold_q <= hold_d;
      first_q <= first_d;
      load_pend_q <= load_pend_d;
      rd_pend_q <= rd_pend_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      mosi_q <= mosi_d;
    end
  end
  assign oMISO = (state_q == DATA && rw_q) ? tx_q[DW-1] : 1'b0;
  assign oWR_EN = wr_en_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_data_q;
  assign oRD_EN = rd_en_q;
  assign oRD_ADDR = rd_addr_q;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed scenario bench with header-decoder and register-file models
module tb_spi_frame_ctrl;
  import spi_ctrl_pkg::*;
  logic iCLK = 1'b0, iRST = 1'b1, iSCLK = 1'b0, iCS_N = 1'b1, MOSI = 1'b0;
  logic oMISO, oDEC_EN, oDEC_CLR, oWR_EN, oRD_EN;
  logic [4:0] oWR_ADDR, oRD_ADDR;
  logic [15:0] oWR_DATA, iRD_DATA;
  logic [5:0] iHEADER;
  logic iHEADER_EN;
  logic [5:0] dsr;
  int dcnt;
  logic hen;
  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, en_cnt = 0, clr_cnt = 0, hen_cnt = 0;
  logic [4:0] wr_addr_l;
  logic [15:0] wr_data_l;
  logic [4:0] rd_log [0:63];
  logic [127:0] miso_cap;
  spi_frame_ctrl #(.DW(16), .SYNC_STAGES(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSCLK(iSCLK), .iCS_N(iCS_N), .MOSI(MOSI),
    .oMISO(oMISO), .oDEC_EN(oDEC_EN), .oDEC_CLR(oDEC_CLR),
    .iHEADER(iHEADER), .iHEADER_EN(iHEADER_EN),
    .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA),
    .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR), .iRD_DATA(iRD_DATA)
  );
  always #5 iCLK = ~iCLK;
  assign iHEADER = dsr;
  assign iHEADER_EN = hen;
  function automatic logic [15:0] rf(input logic [4:0] a);
    case (a)
      5'h1E: rf = 16'h1111;
      5'h1F: rf = 16'h2222;
      5'h00: rf = 16'h3333;
      5'h01: rf = 16'h4444;
      default: rf = 16'hDEAD;
    endcase
  endfunction
  // header decoder model: shifts raw MOSI on each enable, pulses header-valid after the 6th bit
  always @(posedge iCLK) begin
    if (iRST || oDEC_CLR) begin
      dcnt <= 0;
      dsr <= '0;
      hen <= 1'b0;
    end else begin
      hen <= oDEC_EN && dcnt == 5;
      if (oDEC_EN) begin
        dsr <= {dsr[4:0], MOSI};
        dcnt <= dcnt + 1;
      end
    end
    iRD_DATA <= oRD_EN ? rf(oRD_ADDR) : 16'h0;
  end
  // strobe monitor
  always @(negedge iCLK) begin
    if (oWR_EN) begin
      wr_cnt++;
      wr_addr_l = oWR_ADDR;
      wr_data_l = oWR_DATA;
    end
    if (oRD_EN) begin
      rd_log[rd_cnt[5:0]] = oRD_ADDR;
      rd_cnt++;
    end
    if (oDEC_EN) en_cnt++;
    if (oDEC_CLR) clr_cnt++;
    if (iHEADER_EN) hen_cnt++;
  end
  task automatic spi_xfer(input logic [127:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      MOSI = bits[n-1-i];
      repeat (half) @(negedge iCLK);
      miso_cap = {miso_cap[126:0], oMISO};
      iSCLK = 1'b1;
      repeat (half) @(negedge iCLK);
      iSCLK = 1'b0;
    end
  endtask
  task automatic cs_low(input int half);
    iCS_N = 1'b0;
    repeat (half) @(negedge iCLK);
  endtask
  task automatic cs_high(input int half);
    repeat (half) @(negedge iCLK);
    iCS_N = 1'b1;
    MOSI = 1'b0;
    repeat (20) @(negedge iCLK);
  endtask
  task automatic test_reset;
    int w0;
    repeat (5) @(negedge iCLK);
    checks++;
    if ({oMISO, oDEC_EN, oDEC_CLR, oWR_EN, oRD_EN, oWR_ADDR, oRD_ADDR, oWR_DATA} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {oMISO, oDEC_EN, oDEC_CLR, oWR_EN, oRD_EN, oWR_ADDR, oRD_ADDR, oWR_DATA});
    end
    iRST = 1'b0;
    repeat (10) @(negedge iCLK);
    cs_low(4);
    spi_xfer(128'(3'b101), 3, 4);
    iRST = 1'b1;
    @(negedge iCLK);
    checks++;
    if ({oMISO, oDEC_EN, oDEC_CLR, oWR_EN, oRD_EN, oWR_ADDR, oRD_ADDR, oWR_DATA} !== '0) begin
      failures++;
      $display("FAIL midframe_reset_outputs got=%h exp=0", {oMISO, oDEC_EN, oDEC_CLR, oWR_EN, oRD_EN, oWR_ADDR, oRD_ADDR, oWR_DATA});
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL midframe_reset_state got=%0d exp=%0d", dut.state_q, IDLE);
    end
    iCS_N = 1'b1;
    repeat (5) @(negedge iCLK);
    iRST = 1'b0;
    repeat (10) @(negedge iCLK);
    w0 = wr_cnt;
    cs_low(4);
    spi_xfer(128'({6'b000010, 16'h1234}), 22, 4);
    cs_high(4);
    checks++;
    if (wr_cnt - w0 !== 1 || wr_addr_l !== 5'h02 || wr_data_l !== 16'h1234) begin
      failures++;
      $display("FAIL post_reset_write got=%0d/%h/%h exp=1/02/1234", wr_cnt - w0, wr_addr_l, wr_data_l);
    end
  endtask
  task automatic test_write;
    int w0, e0, c0;
    w0 = wr_cnt; e0 = en_cnt; c0 = clr_cnt;
    cs_low(4);
    spi_xfer(128'({6'b000101, 16'hA5C3}), 22, 4);
    cs_high(4);
    checks++;
    if (wr_cnt - w0 !== 1) begin
      failures++;
      $display("FAIL write_count got=%0d exp=1", wr_cnt - w0);
    end
    checks++;
    if (wr_addr_l !== 5'h05 || wr_data_l !== 16'hA5C3) begin
      failures++;
      $display("FAIL write_addr_data got=%h/%h exp=05/a5c3", wr_addr_l, wr_data_l);
    end
    checks++;
    if (en_cnt - e0 !== 6) begin
      failures++;
      $display("FAIL write_dec_en got=%0d exp=6", en_cnt - e0);
    end
    checks++;
    if (clr_cnt - c0 !== 2) begin
      failures++;
      $display("FAIL write_dec_clr got=%0d exp=2", clr_cnt - c0);
    end
  endtask
  task automatic test_read_burst;
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    miso_cap = '0;
    cs_low(8);
    spi_xfer(128'({6'b111110, 48'h0}), 54, 8);
    cs_high(8);
    checks++;
    if (miso_cap[47:0] !== 48'h1111_2222_3333) begin
      failures++;
      $display("FAIL read_miso got=%h exp=111122223333", miso_cap[47:0]);
    end
    checks++;
    if (miso_cap[53:48] !== 6'h0) begin
      failures++;
      $display("FAIL read_miso_header got=%h exp=00", miso_cap[53:48]);
    end
    checks++;
    if (rd_cnt - r0 !== 4 || wr_cnt - w0 !== 0) begin
      failures++;
      $display("FAIL read_strobes got=%0d/%0d exp=4/0", rd_cnt - r0, wr_cnt - w0);
    end
    checks++;
    if ({rd_log[r0[5:0]], rd_log[6'(r0 + 1)], rd_log[6'(r0 + 2)], rd_log[6'(r0 + 3)]} !== {5'h1E, 5'h1F, 5'h00, 5'h01}) begin
      failures++;
      $display("FAIL read_addrs got=%h %h %h %h exp=1e 1f 00 01", rd_log[r0[5:0]], rd_log[6'(r0 + 1)], rd_log[6'(r0 + 2)], rd_log[6'(r0 + 3)]);
    end
  endtask
  task automatic test_abort;
    int w0;
    w0 = wr_cnt;
    cs_low(4);
    spi_xfer(128'({6'b000011, 9'h155}), 15, 4);
    cs_high(4);
    checks++;
    if (wr_cnt - w0 !== 0) begin
      failures++;
      $display("FAIL abort_no_write got=%0d exp=0", wr_cnt - w0);
    end
    checks++;
    if (dut.state_q !== IDLE || oMISO !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got=%0d/%b exp=%0d/0", dut.state_q, oMISO, IDLE);
    end
  endtask
  task automatic test_short;
    int w0, r0, h0, c0;
    w0 = wr_cnt; r0 = rd_cnt; h0 = hen_cnt; c0 = clr_cnt;
    cs_low(4);
    spi_xfer(128'(4'b1010), 4, 4);
    cs_high(4);
    checks++;
    if (hen_cnt - h0 !== 0 || wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
      failures++;
      $display("FAIL short_strobes got=%0d/%0d/%0d exp=0/0/0", hen_cnt - h0, wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if (clr_cnt - c0 !== 2) begin
      failures++;
      $display("FAIL short_clear got=%0d exp=2", clr_cnt - c0);
    end
    w0 = wr_cnt;
    cs_low(4);
    spi_xfer(128'({6'b000111, 16'h0001}), 22, 4);
    cs_high(4);
    checks++;
    if (wr_cnt - w0 !== 1 || wr_addr_l !== 5'h07 || wr_data_l !== 16'h0001) begin
      failures++;
      $display("FAIL short_then_write got=%0d/%h/%h exp=1/07/0001", wr_cnt - w0, wr_addr_l, wr_data_l);
    end
  endtask
  task automatic test_cs_race;
    int w0;
    w0 = wr_cnt;
    cs_low(4);
    spi_xfer(128'({6'b001001, 15'h7FFF}), 21, 4);
    MOSI = 1'b1;
    repeat (4) @(negedge iCLK);
    iSCLK = 1'b1;
    iCS_N = 1'b1;
    repeat (4) @(negedge iCLK);
    iSCLK = 1'b0;
    repeat (20) @(negedge iCLK);
    checks++;
    if (wr_cnt - w0 !== 0) begin
      failures++;
      $display("FAIL cs_race_no_write got=%0d exp=0", wr_cnt - w0);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL cs_race_idle got=%0d exp=%0d", dut.state_q, IDLE);
    end
  endtask
  initial begin
    test_reset;
    test_write;
    test_read_burst;
    test_abort;
    test_short;
    test_cs_race;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
SPI slave frame controller (mode 0, MSB first) that sequences the 6-bit header decoder and runs the data phase of each frame.
- Synchronises SCLK and CS_N into the system clock and generates the decoder's bit-enable and clear.
- Interprets the decoded header: bit 5 is R/W (1 = read), bits 4:0 are the register address.
- Drives a register-file write/read port with burst auto-increment, and shifts read data out on MISO.

Parameters:
DW, 16, data word width per register access (8..32)
SYNC_STAGES, 2, flip-flop synchroniser depth on SCLK and CS_N (>=2)

Ports:
iCLK  in  1  system clock; iCLK frequency >= 8x SCLK frequency
iRST  in  1  synchronous, active-high reset
iSCLK  in  1  SPI clock, asynchronous to iCLK
iCS_N  in  1  SPI chip select, active low, asynchronous
MOSI  in  1  SPI serial input; also wired directly to the decoder's serial input
oMISO  out  1  SPI serial output; 0 whenever not in a read data phase
oDEC_EN  out  1  bit enable to the header decoder
oDEC_CLR  out  1  clear to the header decoder
iHEADER  in  6  decoded header from the decoder
iHEADER_EN  in  1  header-valid pulse from the decoder
oWR_EN  out  1  one-cycle write strobe
oWR_ADDR  out  5  write address
oWR_DATA  out  DW  write data
oRD_EN  out  1  one-cycle read strobe
oRD_ADDR  out  5  read address
iRD_DATA  in  DW  read data, valid exactly 1 cycle after oRD_EN

Behaviour:
- Reset (iRST=1 at an iCLK edge): state=IDLE; all outputs 0; shift registers, counters and address 0; synchroniser flops initialise to SCLK=0, CS_N=1.
- Synchronisation and edge detect:
  - SCLK and CS_N pass through SYNC_STAGES flops, then an edge-detect flop.
  - The MOSI sample is taken from a SYNC_STAGES-deep delay line so it stays aligned with the SCLK samples.
  - rise/fall/cs_act/cs_deact are one-cycle pulses; a pin edge produces its pulse SYNC_STAGES+1 cycles later.
- States:
  - IDLE: on cs_act -> HEADER, with oDEC_CLR=1 for one cycle.
  - HEADER:
    - oDEC_EN = rise.
    - iHEADER_EN=1 -> capture addr=iHEADER[4:0] and rw=iHEADER[5], bitcnt=0, go to DATA.
    - If rw=1, assert oRD_EN with oRD_ADDR=addr on the next cycle.
  - DATA:
    - Each rise shifts the sampled MOSI into rx_sr and increments bitcnt.
    - When bitcnt reaches DW:
      - Write frame: next cycle oWR_EN=1, oWR_ADDR=addr, oWR_DATA=rx_sr.
      - Read frame: next cycle oRD_EN=1 at addr+1 (prefetch).
      - In both cases addr increments mod 32 (0x1F wraps to 0x00) and bitcnt resets to 0.
  - Any state: cs_deact -> IDLE, oDEC_CLR=1 for one cycle, oDEC_EN=0.
- oDEC_EN is never asserted outside HEADER. The decoder's counter is therefore never enabled past its 6th bit within a frame.
- Read path:
  - iRD_DATA is captured into hold_reg on the cycle after oRD_EN.
  - First word of a frame: tx_sr is loaded from iRD_DATA directly on that capture cycle.
  - Later words: tx_sr is loaded from hold_reg on the first fall where bitcnt=0 and the word boundary has passed.
  - Otherwise, a fall with bitcnt in 1..DW-1 shifts tx_sr left by 1.
  - The fall immediately after the 6th header rise does not shift.
  - oMISO = tx_sr[DW-1] in a read DATA phase, else 0.
- Abort: cs_deact before bitcnt reaches DW discards the partial word; no oWR_EN is issued. An already-issued prefetch read is harmless and its data is dropped.
- Simultaneous events:
  - cs_deact has priority over rise in the same cycle; that bit is discarded.
  - cs_act and cs_deact cannot coincide after synchronisation.
- Frames shorter than 6 bits: decoder cleared, no strobes.
- iRST has priority over everything.

Decomposition:
- Shared package spi_ctrl_pkg:
  - state enum {IDLE, HEADER, DATA}
  - HDR_RW_BIT=5, HDR_ADDR_MSB=4, AW=5
- One sub-module: spi_edge_sync (synchroniser + edge detect, parameter SYNC_STAGES), instantiated for SCLK and for CS_N.
- The MOSI delay line lives in the top block.

Test Plan:
1. Reset mid-frame (assert iRST after 3 header bits) -> all outputs 0 next cycle; following frame decodes normally.
2. Write frame: header 0b0_00101, data 0xA5C3, SCLK = iCLK/8 -> exactly one oWR_EN with ADDR=0x05, DATA=0xA5C3; oDEC_EN pulses exactly 6 times; oDEC_CLR pulses at CS fall and CS rise.
3. Read burst: header 0b1_11110, 3 words, model returns 0x1111/0x2222/0x3333 for addresses 0x1E/0x1F/0x00 -> oRD_EN at 0x1E, 0x1F, 0x00, 0x01; MISO bitstream equals 0x1111, 0x2222, 0x3333 MSB first; address wraps.
4. Abort: write header 0b0_00011, then 9 data bits, CS high -> no oWR_EN; state IDLE; oMISO=0.
5. Short frame: 4 bits then CS high -> no iHEADER_EN, no strobes; decoder cleared; next full write frame to 0x07 with 0x0001 is correct.
6. CS deassert in the same synchronised cycle as the 16th rise of a write -> no oWR_EN.
